// File: rtl/alarm_scheduler.sv
// alarm_scheduler: alarm compare, ring/snooze/stop FSM and speaker tone arbitration
module alarm_scheduler #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       _1KHz,
    input  logic       _500Hz,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic [7:0] AlarmHour,
    input  logic [7:0] AlarmMinute,
    input  logic       AlarmEn,
    input  logic       Snooze,
    input  logic       Stop,
    input  logic       CHIME,
    output logic       SPEAKER,
    output logic       RINGING,
    output logic       SNOOZING,
    output logic [1:0] SnoozeCnt
);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_sec_q;
    logic       r_snz_q, r_stp_q;
    logic [6:0] r_ring_cnt, w_ring_cnt;
    logic [3:0] r_snz_cnt, w_snz_cnt;
    logic [1:0] w_snooze_cnt;
    logic       w_sec_tick, w_min_tick, w_snz_p, w_stp_p, w_match, w_tone;
    assign w_sec_tick = Second != r_sec_q;
    assign w_min_tick = w_sec_tick && Second == 8'h00;
    assign w_snz_p    = Snooze && !r_snz_q;
    assign w_stp_p    = Stop && !r_stp_q;
    assign w_match    = AlarmEn && Hour == AlarmHour && Minute == AlarmMinute && w_min_tick;
    assign w_tone     = (r_state == RING) ? (Second[0] ? _500Hz : _1KHz) : CHIME;
    // Next state and counter updates; disarming overrides every transition, Stop beats Snooze
    always_comb begin
        w_next       = r_state;
        w_ring_cnt   = r_ring_cnt;
        w_snz_cnt    = r_snz_cnt;
        w_snooze_cnt = SnoozeCnt;
        if (!AlarmEn)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:
                    if (w_match) begin
                        w_next       = RING;
                        w_ring_cnt   = '0;
                        w_snooze_cnt = '0;
                    end
                RING:
                    if (w_stp_p)
                        w_next = IDLE;
                    else if (w_snz_p && SnoozeCnt < 2'(MAX_SNOOZE)) begin
                        w_next       = SNOOZE;
                        w_snz_cnt    = 4'(SNOOZE_MIN);
                        w_snooze_cnt = SnoozeCnt + 2'd1;
                    end else if (w_sec_tick) begin
                        w_ring_cnt = r_ring_cnt + 7'd1;
                        w_next     = (r_ring_cnt == 7'(RING_SEC - 1)) ? IDLE : RING;
                    end
                SNOOZE:
                    if (w_stp_p)
                        w_next = IDLE;
                    else if (w_min_tick) begin
                        w_snz_cnt  = r_snz_cnt - 4'd1;
                        w_next     = (r_snz_cnt == 4'd1) ? RING : SNOOZE;
                        w_ring_cnt = (r_snz_cnt == 4'd1) ? '0 : r_ring_cnt;
                    end
                default: w_next = IDLE;
            endcase
    end
    // State, counters, edge-detect copies and registered outputs; reset primes edge copies with live inputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            SnoozeCnt  <= '0;
            SPEAKER    <= 1'b0;
            RINGING    <= 1'b0;
            SNOOZING   <= 1'b0;
            r_sec_q    <= Second;
            r_snz_q    <= Snooze;
            r_stp_q    <= Stop;
        end else begin
            r_state    <= w_next;
            r_ring_cnt <= w_ring_cnt;
            r_snz_cnt  <= w_snz_cnt;
            SnoozeCnt  <= w_snooze_cnt;
            SPEAKER    <= w_tone;
            RINGING    <= w_next == RING;
            SNOOZING   <= w_next == SNOOZE;
            r_sec_q    <= Second;
            r_snz_q    <= Snooze;
            r_stp_q    <= Stop;
        end
    end
endmodule
